// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: fetch-stage sequencer owning the PC and the instruction-memory port.
// Keeps one fetch outstanding at a time and arbitrates CSR and execute redirects
// (csr wins) against sequential fetch. A fetched word is held for decode under stall.
// Data from a fetch that a redirect has made stale is dropped.
// Optional feature: define FETCH_MISALIGN_CHK_EN to trap misaligned jump targets
// into a TRAPWAIT state. When it is undefined, redirect targets are word-aligned.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_8000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        jump_valid,
  input  logic [31:0] jump_addr,
  input  logic        csr_valid,
  input  logic [31:0] csr_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc_plus4,
  output logic        flush,
  output logic        misalign_valid,
  output logic [31:0] misalign_addr
);

`ifdef FETCH_MISALIGN_CHK_EN
  typedef enum logic [2:0] {StReset, StIssue, StWait, StHold, StTrapWait} state_e;
`else
  typedef enum logic [1:0] {StReset, StIssue, StWait, StHold} state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        discard_q, discard_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;

  logic        redir_req;
  logic        accept;
  logic [31:0] target;
  logic        busy;  // a fetch is still outstanding after this cycle

`ifdef FETCH_MISALIGN_CHK_EN
  logic        jump_bad;
  logic        mis_valid_q, mis_valid_d;
  logic [31:0] mis_addr_q, mis_addr_d;
`endif

  // Redirect decode: pick the winning source and decide whether it is accepted.
  always_comb begin
    redir_req = csr_valid | jump_valid;
`ifdef FETCH_MISALIGN_CHK_EN
    target    = csr_valid ? csr_pc : jump_addr;
    jump_bad  = !csr_valid && jump_valid && (jump_addr[1:0] != 2'b00);
    // While trapped only the CSR unit may steer fetch.
    if (state_q == StTrapWait) begin
      redir_req = csr_valid;
    end
`else
    target    = (csr_valid ? csr_pc : jump_addr) & 32'hFFFF_FFFC;
`endif
    accept = (state_q != StReset) && redir_req;
  end

  // Next-state and output decode.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    if_pc_d   = if_pc_q;
    if_inst_d = if_inst_q;
    imem_req  = 1'b0;
    if_valid  = 1'b0;
    flush     = 1'b0;
    busy      = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    mis_valid_d = 1'b0;
    mis_addr_d  = mis_addr_q;
`endif

    unique case (state_q)
      StReset: begin
        state_d = StIssue;
      end
      StIssue: begin
        imem_req = 1'b1;
        busy     = imem_gnt;
        if (!accept && imem_gnt) begin
          state_d = StWait;
        end
      end
      StWait: begin
        busy = !imem_rvalid;
        if (!accept && imem_rvalid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = StIssue;
          end else begin
            if_pc_d   = pc_q;
            if_inst_d = imem_rdata;
            state_d   = StHold;
          end
        end
      end
      StHold: begin
        if_valid = 1'b1;
        if (!accept && !stall) begin
          pc_d    = pc_q + 32'd4;
          state_d = StIssue;
        end
      end
`ifdef FETCH_MISALIGN_CHK_EN
      StTrapWait: begin
        // Drain whatever fetch was in flight when the trap was taken.
        busy = discard_q && !imem_rvalid;
        if (imem_rvalid) begin
          discard_d = 1'b0;
        end
      end
`endif
      default: begin
        state_d = StReset;
      end
    endcase

    // An accepted redirect overrides the per-state decisions; a fetch still in
    // flight must be drained through WAIT before the new target is requested.
    if (accept) begin
      flush     = 1'b1;
      discard_d = busy;
      pc_d      = target;
      state_d   = busy ? StWait : StIssue;
`ifdef FETCH_MISALIGN_CHK_EN
      if (jump_bad) begin
        pc_d        = pc_q;
        state_d     = StTrapWait;
        mis_valid_d = 1'b1;
        mis_addr_d  = jump_addr;
      end
`endif
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StReset;
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
      if_pc_q   <= 32'd0;
      if_inst_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
      if_pc_q   <= if_pc_d;
      if_inst_q <= if_inst_d;
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  // Misalignment report registers; valid is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mis_valid_q <= 1'b0;
      mis_addr_q  <= 32'd0;
    end else begin
      mis_valid_q <= mis_valid_d;
      mis_addr_q  <= mis_addr_d;
    end
  end

  assign misalign_valid = mis_valid_q;
  assign misalign_addr  = mis_addr_q;
`else
  assign misalign_valid = 1'b0;
  assign misalign_addr  = 32'd0;
`endif

  assign imem_addr   = pc_q;
  assign if_pc       = if_pc_q;
  assign if_inst     = if_inst_q;
  assign if_pc_plus4 = if_pc_q + 32'd4;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Testbench for fetch_pc_ctrl: memory model with programmable latency, address and
// instruction scoreboards, a vector table for sequential fetch with stalls, and
// hand-written redirect, wrap, misalignment and mid-operation reset sequences.
module tb_fetch_pc_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall;
  logic        jump_valid;
  logic [31:0] jump_addr;
  logic        csr_valid;
  logic [31:0] csr_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [31:0] if_pc_plus4;
  logic        flush;
  logic        misalign_valid;
  logic [31:0] misalign_addr;

  always #5 clk = ~clk;

  fetch_pc_ctrl dut (
    .clk           (clk),
    .rstn          (rstn),
    .stall         (stall),
    .jump_valid    (jump_valid),
    .jump_addr     (jump_addr),
    .csr_valid     (csr_valid),
    .csr_pc        (csr_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .if_pc_plus4   (if_pc_plus4),
    .flush         (flush),
    .misalign_valid(misalign_valid),
    .misalign_addr (misalign_addr)
  );

  int checks = 0;
  int errors = 0;

  // Memory model state.
  bit          gnt_en = 1'b1;
  int          lat = 1;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = 32'd0;

  // Scoreboards: expected grant addresses and expected presented PCs.
  logic [31:0] addr_q[$];
  logic [31:0] pc_q[$];

  typedef struct {
    int          stall_cyc;
    int          exp_wait;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[4];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock: memory responds at the falling edge, outputs sampled 1 after rising edge.
  task automatic step();
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b0;
    if (pend) begin
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = inst_of(paddr);
        pend        = 1'b0;
      end else begin
        cnt--;
      end
    end
    if (imem_req === 1'b1 && gnt_en && !pend) begin
      imem_gnt = 1'b1;
      pend     = 1'b1;
      paddr    = imem_addr;
      cnt      = lat - 1;
      if (addr_q.size() > 0) chk("imem_addr_at_gnt", imem_addr, addr_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  // Step until if_valid (bounded), then score the presented instruction.
  task automatic wait_valid(input int maxc, input int exp_cyc);
    int          n;
    logic [31:0] e;
    n = 0;
    while (if_valid !== 1'b1 && n < maxc) begin
      step();
      n++;
    end
    chk("if_valid_arrives", if_valid, 1'b1);
    if (exp_cyc >= 0) chk("fetch_latency", n, exp_cyc);
    if (pc_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got if_pc 0x%08h expected no instruction", if_pc);
    end else begin
      e = pc_q.pop_front();
      chk("if_pc", if_pc, e);
      chk("if_inst", if_inst, inst_of(e));
      chk("if_pc_plus4", if_pc_plus4, e + 32'd4);
    end
  endtask

  task automatic consume();
    stall = 1'b0;
    step();
  endtask

  initial begin
    rstn        = 1'b0;
    stall       = 1'b0;
    jump_valid  = 1'b1;
    jump_addr   = 32'h0000_1234;
    csr_valid   = 1'b0;
    csr_pc      = 32'd0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;

    // Reset values; a redirect request in RESET must not flush.
    step();
    step();
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_if_valid", if_valid, 1'b0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    chk("rst_flush", flush, 1'b0);
    chk("rst_misalign_valid", misalign_valid, 1'b0);
    chk("rst_misalign_addr", misalign_addr, 32'd0);
    jump_valid = 1'b0;
    rstn       = 1'b1;
    #1;
    chk("reset_state_flush", flush, 1'b0);

    // Sequential fetch with decode stalls.
    tbl[0] = '{0, 3, 32'h0000_8000};
    tbl[1] = '{4, 2, 32'h0000_8004};
    tbl[2] = '{0, 2, 32'h0000_8008};
    tbl[3] = '{2, 2, 32'h0000_800C};
    for (int i = 0; i < 4; i++) begin
      addr_q.push_back(tbl[i].exp_pc);
      pc_q.push_back(tbl[i].exp_pc);
    end
    for (int i = 0; i < 4; i++) begin
      wait_valid(10, tbl[i].exp_wait);
      stall = 1'b1;
      for (int k = 0; k < tbl[i].stall_cyc; k++) begin
        step();
        chk("stall_if_valid", if_valid, 1'b1);
        chk("stall_if_pc", if_pc, tbl[i].exp_pc);
        chk("stall_if_inst", if_inst, inst_of(tbl[i].exp_pc));
        chk("stall_no_req", imem_req, 1'b0);
      end
      consume();
    end
    chk("seq_next_addr", imem_addr, 32'h0000_8010);

    // Jump during WAIT; stale data returns two cycles later and is dropped.
    lat = 3;
    addr_q.push_back(32'h0000_8010);
    step();
    jump_valid = 1'b1;
    jump_addr  = 32'h0000_9000;
    #1;
    chk("jump_wait_flush", flush, 1'b1);
    step();
    jump_valid = 1'b0;
    #1;
    chk("flush_one_cycle", flush, 1'b0);
    step();
    chk("drain_no_req", imem_req, 1'b0);
    step();
    chk("drain_if_valid", if_valid, 1'b0);
    chk("after_drain_req", imem_req, 1'b1);
    chk("after_drain_addr", imem_addr, 32'h0000_9000);
    lat = 1;
    addr_q.push_back(32'h0000_9000);
    pc_q.push_back(32'h0000_9000);
    wait_valid(10, 2);
    consume();

    // CSR and jump together in ISSUE with grant: CSR wins, granted fetch is stale.
    addr_q.push_back(32'h0000_9004);
    csr_valid  = 1'b1;
    csr_pc     = 32'h0000_0100;
    jump_valid = 1'b1;
    jump_addr  = 32'h0000_0200;
    #1;
    chk("csr_jump_flush", flush, 1'b1);
    step();
    csr_valid  = 1'b0;
    jump_valid = 1'b0;
    chk("csr_discard_wait_no_req", imem_req, 1'b0);
    step();
    chk("csr_drop_if_valid", if_valid, 1'b0);
    chk("csr_req", imem_req, 1'b1);
    chk("csr_addr", imem_addr, 32'h0000_0100);
    addr_q.push_back(32'h0000_0100);
    pc_q.push_back(32'h0000_0100);
    wait_valid(10, 2);
    consume();

    // Redirect in ISSUE without grant: address moves, request stays up.
    gnt_en     = 1'b0;
    jump_valid = 1'b1;
    jump_addr  = 32'h0000_0300;
    #1;
    chk("issue_nognt_flush", flush, 1'b1);
    step();
    jump_valid = 1'b0;
    chk("issue_nognt_req", imem_req, 1'b1);
    chk("issue_nognt_addr", imem_addr, 32'h0000_0300);
    gnt_en = 1'b1;
    addr_q.push_back(32'h0000_0300);
    pc_q.push_back(32'h0000_0300);
    wait_valid(10, 2);

    // Redirect in HOLD while decode is stalled drops the held instruction.
    stall      = 1'b1;
    jump_valid = 1'b1;
    jump_addr  = 32'h0000_0400;
    #1;
    chk("hold_redirect_flush", flush, 1'b1);
    step();
    jump_valid = 1'b0;
    stall      = 1'b0;
    chk("hold_redirect_if_valid", if_valid, 1'b0);
    chk("hold_redirect_addr", imem_addr, 32'h0000_0400);

    // PC wrap at the top of the address space.
    gnt_en     = 1'b0;
    jump_valid = 1'b1;
    jump_addr  = 32'hFFFF_FFFC;
    step();
    jump_valid = 1'b0;
    gnt_en     = 1'b1;
    addr_q.push_back(32'hFFFF_FFFC);
    pc_q.push_back(32'hFFFF_FFFC);
    wait_valid(10, 2);
    chk("wrap_pc_plus4", if_pc_plus4, 32'h0000_0000);
    consume();
    chk("wrap_req", imem_req, 1'b1);
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    addr_q.push_back(32'h0000_0000);
    pc_q.push_back(32'h0000_0000);
    wait_valid(10, 2);
    consume();

    // Misaligned jump target taken in ISSUE together with a grant.
    addr_q.push_back(32'h0000_0004);
    jump_valid = 1'b1;
    jump_addr  = 32'h0000_9002;
    #1;
    chk("misalign_jump_flush", flush, 1'b1);
    step();
    jump_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    chk("misalign_valid", misalign_valid, 1'b1);
    chk("misalign_addr", misalign_addr, 32'h0000_9002);
    chk("trap_no_req", imem_req, 1'b0);
    step();
    chk("misalign_pulse_end", misalign_valid, 1'b0);
    chk("trap_drain_no_req", imem_req, 1'b0);
    jump_valid = 1'b1;
    jump_addr  = 32'h0000_0500;
    #1;
    chk("trap_ignores_jump", flush, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("trap_idle_no_req", imem_req, 1'b0);
    end
    jump_valid = 1'b0;
    csr_valid  = 1'b1;
    csr_pc     = 32'h0000_0100;
    #1;
    chk("trap_csr_flush", flush, 1'b1);
    step();
    csr_valid = 1'b0;
    chk("trap_exit_req", imem_req, 1'b1);
    chk("trap_exit_addr", imem_addr, 32'h0000_0100);
    addr_q.push_back(32'h0000_0100);
    pc_q.push_back(32'h0000_0100);
`else
    chk("misalign_valid_tied", misalign_valid, 1'b0);
    chk("misalign_addr_tied", misalign_addr, 32'd0);
    chk("misalign_discard_wait", imem_req, 1'b0);
    step();
    chk("aligned_req", imem_req, 1'b1);
    chk("aligned_addr", imem_addr, 32'h0000_9000);
    addr_q.push_back(32'h0000_9000);
    pc_q.push_back(32'h0000_9000);
`endif
    wait_valid(10, 2);
    consume();

    // Reset while a fetch is in flight: the late rvalid must be ignored.
    lat = 3;
    step();
    rstn = 1'b0;
    step();
    chk("midrst_req", imem_req, 1'b0);
    chk("midrst_if_valid", if_valid, 1'b0);
    chk("midrst_if_pc", if_pc, 32'd0);
    chk("midrst_if_inst", if_inst, 32'd0);
    chk("midrst_misalign", misalign_valid, 1'b0);
    rstn = 1'b1;
    lat  = 1;
    addr_q.delete();
    addr_q.push_back(32'h0000_8000);
    pc_q.delete();
    pc_q.push_back(32'h0000_8000);
    wait_valid(12, -1);
    consume();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_ctrl.md
# fetch_pc_ctrl

Fetch-stage sequencer that owns the program counter and drives the instruction-memory port. It arbitrates PC redirects from the CSR/trap unit and the execute-stage jump/branch resolver against sequential fetch, with one outstanding fetch at a time. Fetched instructions are held for decode under a decode stall, and stale in-flight fetches are discarded after a redirect. It sits between the instruction memory and decode and replaces free-running next-PC selection with a handshaked controller.

## Interface

- RESET_PC, 32'h00008000, PC loaded at reset

- clk  in  1  clock, all state on rising edge
- rstn  in  1  reset, synchronous, active-low
- stall  in  1  decode cannot accept; holds presented instruction
- jump_valid  in  1  execute redirect request, single-cycle
- jump_addr  in  32  execute redirect target
- csr_valid  in  1  trap/xRET redirect request, single-cycle
- csr_pc  in  32  CSR redirect target
- imem_req  out  1  fetch request, held until imem_gnt
- imem_addr  out  32  fetch address, equals pc while imem_req
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid, earliest one cycle after gnt
- imem_rdata  in  32  instruction word
- if_valid  out  1  instruction presented to decode
- if_pc  out  32  PC of presented instruction
- if_inst  out  32  presented instruction
- if_pc_plus4  out  32  if_pc + 4, mod 2^32
- flush  out  1  one-cycle pulse when a redirect is accepted
- misalign_valid  out  1  misaligned redirect target detected (see Configuration)
- misalign_addr  out  32  offending target

## Operation

- States: RESET, ISSUE, WAIT, HOLD, TRAPWAIT (TRAPWAIT only with macro).
- Registers: pc, discard flag, if_pc, if_inst.
- Redirect priority: csr_valid > jump_valid. A redirect is accepted in any non-RESET state, regardless of stall. On acceptance: pc <= target, flush = 1 in the same cycle.
- RESET: imem_req = 0. Next state is ISSUE.
- ISSUE: imem_req = 1, imem_addr = pc.
  - gnt without redirect: go to WAIT.
  - gnt and redirect in the same cycle: go to WAIT with discard = 1; the granted fetch is stale.
  - redirect without gnt: stay in ISSUE with the new pc. imem_addr changes only after redirect acceptance.
- WAIT: on rvalid:
  - discard = 1, or redirect in the same cycle: drop the data, clear discard, go to ISSUE.
  - otherwise: if_pc <= pc, if_inst <= rdata, go to HOLD.
  - A redirect without rvalid sets discard = 1 and updates pc. The latest redirect wins.
- HOLD: if_valid = 1.
  - redirect: drop the instruction, go to ISSUE.
  - !stall: instruction consumed; pc <= pc + 4 (wraps 0xFFFFFFFC -> 0), go to ISSUE.
  - stall: stay; if_* stay stable.
- Arithmetic is 32-bit unsigned. The carry is discarded.

## Timing

- Reset values (cycle after rstn sampled low): state = RESET, pc = RESET_PC, discard = 0, imem_req = 0, if_valid = 0, if_pc = 0, if_inst = 0, flush = 0, misalign_valid = 0, misalign_addr = 0.
- Reset mid-operation: an in-flight rvalid after reset is ignored. Outputs go to reset values the cycle after rstn is sampled low.
- imem_req, imem_addr and if_valid are decoded from registered state only. flush is combinational from the redirect inputs in states ISSUE, WAIT, HOLD and TRAPWAIT.
- Minimum throughput with rvalid one cycle after gnt and no stall: one instruction per 3 cycles (ISSUE, WAIT, HOLD).
- Latency: redirect accepted in cycle N gives imem_req with the new address in cycle N+1, or cycle N+1 after stale-data drain in WAIT.

## Configuration

- FETCH_MISALIGN_CHK_EN defined:
  - A jump_valid target with addr[1:0] != 0 is not followed. Instead: misalign_valid pulses 1 cycle, misalign_addr = target, flush pulses, go to TRAPWAIT.
  - An in-flight fetch in TRAPWAIT is drained and dropped.
  - TRAPWAIT issues no fetches until csr_valid, which redirects normally.
  - csr_pc is never checked.
- Undefined:
  - Redirect targets have bits [1:0] forced to 0.
  - misalign_valid and misalign_addr are tied to 0; the ports remain present.
  - There is no TRAPWAIT state.

## Test plan

- Reset release, memory returning rvalid one cycle after gnt -> imem_addr sequence 0x8000, 0x8004, 0x8008; if_valid every third cycle with matching if_pc and if_pc_plus4.
- stall held 4 cycles in HOLD -> if_valid, if_pc and if_inst stable; no imem_req until stall drops; next address is pc + 4.
- jump_valid = 0x9000 in WAIT, rvalid 2 cycles later -> flush pulse; that rdata dropped; next imem_addr = 0x9000; if_pc = 0x9000.
- csr_valid = 0x100 and jump_valid = 0x200 in the same cycle during ISSUE with gnt -> flush; discard set; next fetch at 0x100.
- pc = 0xFFFFFFFC, consumed -> next imem_addr = 0x00000000; if_pc_plus4 = 0x00000000.
- With macro, jump_addr = 0x9002 -> misalign_valid = 1 for one cycle, misalign_addr = 0x9002; no fetch until csr_valid = 0x100, then fetch at 0x100. Without macro -> fetch at 0x9000.
